// File: rtl/sdm_pcm_i2s_tx.sv
// rtl/sdm_pcm_i2s_tx.sv - PCM sample FIFO feeding a mono-to-stereo I2S transmitter
//
// Buffers 16-bit signed samples from the decimator and serialises each one
// onto both I2S channels, MSB first, with the standard one-bit I2S delay.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      runs the serial interface; low holds it idle (FIFO still fills)
//   valid_in    one-cycle strobe qualifying din
//   din         signed 16-bit sample
//   i2s_bclk    bit clock, HALF_DIV clk cycles per half-period
//   i2s_lrclk   word select, 0 = left, 1 = right
//   i2s_sd      serial data, changes with the falling edge of i2s_bclk
//   fifo_level  current FIFO occupancy
//   overflow    one-cycle pulse when a sample is dropped
//   underflow   one-cycle pulse when a frame starts with the FIFO empty
module sdm_pcm_i2s_tx #(
    parameter int HALF_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        valid_in,
    input  logic [15:0]                 din,
    output logic                        i2s_bclk,
    output logic                        i2s_lrclk,
    output logic                        i2s_sd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [7:0]       DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [7:0]       div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       slot_q, slot_d;
    logic             lrclk_q, lrclk_d;
    logic             sd_q, sd_d;
    logic [15:0]      cur_q, cur_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [15:0]      fifo_mem [FIFO_DEPTH];

    logic             div_tick;
    logic             bclk_fall;
    logic             frame_wrap;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [3:0]       sd_idx;

    assign div_tick   = enable && (div_q == DIV_LAST);
    assign bclk_fall  = div_tick && bclk_q;
    assign frame_wrap = bclk_fall && (slot_q == 5'd31);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_FULL);
    assign pop        = frame_wrap && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = valid_in && (!fifo_full || pop);

    always_comb begin
        div_d    = div_q;
        bclk_d   = bclk_q;
        slot_d   = slot_q;
        lrclk_d  = lrclk_q;
        sd_d     = sd_q;
        cur_d    = cur_q;
        sd_idx   = 4'd0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = valid_in && fifo_full && !pop;
        udf_d    = frame_wrap && fifo_empty;

        if (!enable) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            slot_d  = 5'd0;
            lrclk_d = 1'b0;
            sd_d    = 1'b0;
            cur_d   = 16'd0;
        end else begin
            if (div_tick) begin
                div_d  = 8'd0;
                bclk_d = !bclk_q;
            end else begin
                div_d  = div_q + 8'd1;
            end
            if (bclk_fall) begin
                slot_d  = slot_q + 5'd1;
                lrclk_d = slot_d[4];
                // Slots 1..16 send cur[16-slot], 17..31 send cur[32-slot]; both
                // reduce to cur[(-slot) mod 16]. In slot 0 the same index 0 picks
                // the LSB of the word being retired, since cur_q is still the
                // previous sample on the wrap edge.
                sd_idx  = 4'd0 - slot_d[3:0];
                sd_d    = cur_q[sd_idx];
            end
            if (pop) begin
                cur_d = fifo_mem[rd_ptr_q];
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= 8'd0;
            bclk_q   <= 1'b0;
            slot_q   <= 5'd0;
            lrclk_q  <= 1'b0;
            sd_q     <= 1'b0;
            cur_q    <= 16'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            slot_q   <= slot_d;
            lrclk_q  <= lrclk_d;
            sd_q     <= sd_d;
            cur_q    <= cur_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= din;
        end
    end

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sd     = sd_q;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: doc/sdm_pcm_i2s_tx.md
SDM_PCM_I2S_TX -- requirements
Module: sdm_pcm_i2s_tx

Interface
REQ-001 Parameter HALF_DIV, default 4, is the number of clk cycles per BCLK half-period; legal range is 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of 16-bit sample entries buffered; it is a power of two, 2..16.
REQ-003 Port clk  input  1  is the system clock; every flop in the block is clocked on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port enable  input  1  starts the serial interface when high; when low, the interface is held idle.
REQ-006 Port valid_in  input  1  is a one-cycle strobe marking din as a new sample from the upstream averaging decimator.
REQ-007 Port din  input  16  is the signed two's-complement audio sample.
REQ-008 Port i2s_bclk  output  1  is the I2S bit clock.
REQ-009 Port i2s_lrclk  output  1  is the I2S word select: low selects the left channel, high selects the right channel.
REQ-010 Port i2s_sd  output  1  is the I2S serial data, MSB first.
REQ-011 Port fifo_level  output  $clog2(FIFO_DEPTH)+1  is the current FIFO occupancy.
REQ-012 Port overflow  output  1  is a one-cycle pulse raised when a sample is dropped.
REQ-013 Port underflow  output  1  is a one-cycle pulse raised when a frame finds the FIFO empty.

Function
REQ-014 On every cycle with valid_in=1 and the FIFO not full, the block SHALL write din into the FIFO.
REQ-015 When valid_in=1 and the FIFO is full with no pop in the same cycle, the block SHALL drop the sample, leave the contents unchanged and pulse overflow for one cycle.
REQ-016 A push and a pop in the same cycle SHALL be handled as follows:
  - full FIFO: the push is accepted and fifo_level is unchanged;
  - empty FIFO: the pop takes the underflow path (REQ-024), and the push is then stored, so fifo_level becomes 1.
REQ-017 The divider counter SHALL run only while enable=1; on each count of HALF_DIV cycles it SHALL toggle i2s_bclk.
REQ-018 The first rising edge of i2s_bclk SHALL occur HALF_DIV cycles after enable is sampled high, and the first falling edge HALF_DIV cycles after that.
REQ-019 A 5-bit slot counter, slot, SHALL advance by one, mod 32, in the clk cycle in which i2s_bclk goes 1->0; i2s_lrclk and i2s_sd SHALL update in that same cycle.
REQ-020 i2s_lrclk SHALL be 0 for slots 0..15 and 1 for slots 16..31.
REQ-021 i2s_sd SHALL be driven per slot as follows:
  - slot 0: prev_word[0];
  - slots 1..16: cur_word[16-slot];
  - slots 17..31: cur_word[32-slot].
  This gives the standard I2S one-bit delay: the right-channel LSB falls in slot 0 of the next frame.
REQ-022 The same cur_word SHALL be sent on both channels (mono duplicated to stereo).
REQ-023 On each slot 31->0 transition, the block SHALL copy prev_word <= cur_word and, if the FIFO is non-empty, pop the head into cur_word.
REQ-024 If the FIFO is empty at the slot 31->0 transition, cur_word SHALL keep its value (the last sample repeats) and underflow SHALL pulse for one cycle.
REQ-025 When enable goes low, the block SHALL clear the divider and slot, and drive i2s_bclk=0, i2s_lrclk=0 and i2s_sd=0 on the next cycle.
REQ-026 While enable is low, cur_word and prev_word SHALL be cleared to 0, and the FIFO SHALL keep accepting writes.
REQ-027 In the first frame after enable rises, the block SHALL output zeros; the first pop happens at the first slot 31->0 transition (32 BCLK periods after enable).
REQ-028 One frame SHALL last 64*HALF_DIV clk cycles; the upstream sample rate must not exceed one sample per frame, otherwise overflow reports the loss.

Reset
REQ-029 While rst_n=0, the block SHALL drive i2s_bclk=0, i2s_lrclk=0, i2s_sd=0, fifo_level=0, overflow=0 and underflow=0, and clear the FIFO pointers, divider, slot, cur_word and prev_word.
REQ-030 rst_n SHALL be asserted asynchronously and released synchronously to clk by the system reset logic; after release the block SHALL behave as if enable had just risen.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, and any buffered samples SHALL be discarded.

Verification (HALF_DIV=2, FIFO_DEPTH=4)
REQ-032 The bench SHALL cover these directed scenarios:
  - Enable after reset, with a push of 0x8001 during frame 0 -> frame 0 is all zeros. Frame 1: slots 1..16 carry 1000000000000001, lrclk falls every 128 cycles, and the BCLK period is 4 clk cycles.
  - Five pushes 0x1111..0x5555 in consecutive cycles with enable=0 -> fifo_level reaches 4, overflow pulses once on the fifth push, and 0x5555 never appears on i2s_sd.
  - A single sample 0x7FFF, then no further pushes -> frames 1 and 2 both carry 0x7FFF on both channels, and underflow pulses at the start of frame 2.
  - Frame 1 carries 0x0001 and frame 2 carries 0xFFFE -> slot 0 of frame 2 outputs 1 (the right LSB of 0x0001), then slot 1 outputs 1 (the MSB of 0xFFFE).
  - Push coincident with the pop cycle on an empty FIFO -> underflow=1 and fifo_level=1 afterwards; the sample appears in the following frame.
  - rst_n pulled low at slot 20 -> all outputs are 0 within the same cycle, and fifo_level=0 on release.
